pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Fetch/decode/execute controller for the 16-bit program counter.
//   - Drives the counter's res/load/inc controls and its jump target.
//   - Handshakes with instruction memory to fetch each instruction.
//   - Evaluates Hack jump bits (instr[2:0]) against the ALU flags zr/ng.
//   - Emits a one-cycle commit strobe to the datapath per instruction.
// PARAMETERS
//   WIDTH    16  PC, target and instruction width
//   TIMEOUT  15  max cycles in FETCH without imem_ack before FAULT
// PORTS
//   clk        in   1      single clock, rising edge
//   res_n      in   1      asynchronous, active-low reset
//   run        in   1      level; 1 = execute program, 0 = stop at instruction boundary
//   imem_req   out  1      fetch request, held until imem_ack
//   imem_ack   in   1      instruction valid on instr this cycle
//   instr      in   WIDTH  fetched instruction
//   zr         in   1      ALU result == 0
//   ng         in   1      ALU result < 0
//   a_reg      in   WIDTH  jump target (A register)
//   pc         in   WIDTH  current counter value
//   pc_res     out  1      counter reset control
//   pc_load    out  1      counter load control
//   pc_inc     out  1      counter increment control
//   pc_target  out  WIDTH  counter load data
//   exec_en    out  1      one-cycle commit strobe to the datapath
//   busy       out  1      state != IDLE
//   fault      out  1      sticky fetch-timeout flag
//   halted     out  1      self-loop detected (see CONFIGURATION)
// BEHAVIOUR
//   - States: IDLE, FETCH, DECODE, EXEC, FAULT (+HALT). Outputs are Moore, decoded from registered state/ir/take.
//   - Reset (res_n=0, async): state=IDLE, ir=0, take=0, timeout cnt=0.
//     Outputs under reset: pc_res=1; all other outputs 0.
//   - IDLE: pc_res=1. Goes to FETCH when run=1.
//   - FETCH: imem_req=1. The timeout counter starts at 0 on entry.
//     - imem_ack=1 (including the first FETCH cycle): ir<=instr, go to DECODE.
//     - Otherwise cnt++. When cnt reaches TIMEOUT-1 with no ack, go to FAULT.
//   - DECODE: take <= ir[15] & ((ir[2]&ng) | (ir[1]&zr) | (ir[0]&~zr&~ng)).
//     - flags are sampled in this cycle only.
//     - A-instruction (ir[15]=0) never jumps.
//   - EXEC: exec_en=1; pc_load=take; pc_inc=~take; pc_target=a_reg.
//     - Next state is FETCH if run=1, else IDLE.
//   - pc_res, pc_load, pc_inc are mutually exclusive. Priority is res > load > inc, matching the counter.
//   - Latency: 3 cycles per instruction minimum (FETCH, DECODE, EXEC), plus ack wait cycles.
//   - run=0 mid-instruction: the instruction completes; IDLE is entered after EXEC.
//   - imem_ack outside FETCH is ignored.
//   - FAULT: fault=1, imem_req=0, pc_* = 0, exec_en never asserted. Exits only via res_n.
//   - Reset mid-operation aborts immediately. No partial exec_en or pc_load is produced.
//   - pc_target is WIDTH bits, no arithmetic. Wrap-around of pc is the counter's concern.
// CONFIGURATION
//   Macro PC_SEQ_HALT_DETECT_EN.
//   - Defined: in DECODE, if ir[15]=1, ir[2:0]=3'b111 and a_reg==pc, go to HALT.
//     - HALT: halted=1, imem_req=0, exec_en=0, pc_* = 0.
//     - Exit to IDLE when run=0.
//   - Undefined: no HALT state; halted tied to 0. A self-jump loops normally with pc_load=1 in each EXEC.
// STRUCTURE
//   Package hack_cpu_pkg:
//     - state encoding constants
//     - INSTR_TYPE_BIT=15
//     - JGT/JEQ/JLT bit indices 0/1/2
//   Sub-module jump_cond (combinational): ir[15], ir[2:0], zr, ng -> take. Reusable by the CPU core.
//   Remaining logic: FSM, timeout counter, ir/take registers, output decode.
// TESTING
//   1. Reset during FETCH (imem_req=1) -> same cycle imem_req=0, pc_res=1, busy=0, fault=0.
//   2. run=1, instr=16'h0005, ack after 2 wait cycles -> one exec_en pulse, pc_inc=1, pc_load=0; 5 cycles FETCH-entry to EXEC-exit.
//   3. instr=16'hE302 (JEQ), a_reg=16'h0040:
//        zr=1 -> pc_load=1, pc_target=16'h0040
//        zr=0 -> pc_inc=1
//   4. instr=16'hE307 (JMP), any flags -> pc_load=1. instr=16'hE301 (JGT), zr=0, ng=1 -> pc_inc=1.
//   5. No imem_ack with TIMEOUT=15 -> FAULT after 15 FETCH cycles: fault=1, imem_req=0.
//      Stays in FAULT with run=1 until res_n.
//   6. pc=a_reg=16'h0010, instr=16'hEA87:
//        PC_SEQ_HALT_DETECT_EN defined -> halted=1, no further imem_req
//        undefined -> pc_load=1 every EXEC, fetches continue

Source files
------------

// File: rtl/hack_cpu_pkg.sv
// Shared definitions for the Hack CPU control path.
//   - FSM state encoding used by pc_sequencer
//   - Instruction field bit positions (C/A type bit, jump bits)
package hack_cpu_pkg;

    // Bit 15 set marks a C-instruction; clear marks an A-instruction.
    localparam int INSTR_TYPE_BIT = 15;

    // Jump field bit indices within instr[2:0].
    localparam int JGT_BIT = 0;
    localparam int JEQ_BIT = 1;
    localparam int JLT_BIT = 2;

    // Unconditional jump encoding (JMP).
    localparam logic [2:0] JMP_ALWAYS = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_FAULT  = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/jump_cond.sv
// Hack jump condition evaluator (purely combinational).
// Ports:
//   is_c_i  : instruction type bit (1 = C-instruction)
//   jump_i  : jump field instr[2:0] (JLT, JEQ, JGT)
//   zr_i    : ALU result is zero
//   ng_i    : ALU result is negative
//   take_o  : jump is taken
module jump_cond
    import hack_cpu_pkg::*;
(
    input  logic       is_c_i,
    input  logic [2:0] jump_i,
    input  logic       zr_i,
    input  logic       ng_i,
    output logic       take_o
);

    // Positive result is neither zero nor negative.
    assign take_o = is_c_i & ((jump_i[JLT_BIT] & ng_i) |
                              (jump_i[JEQ_BIT] & zr_i) |
                              (jump_i[JGT_BIT] & ~zr_i & ~ng_i));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller for the Hack program counter.
// Drives the counter's res/load/inc controls, fetches instructions over a
// req/ack handshake, evaluates the jump condition in DECODE and issues a
// one-cycle commit strobe in EXEC. A fetch that waits TIMEOUT cycles
// without ack locks the sequencer in FAULT until reset.
// Optional feature: define PC_SEQ_HALT_DETECT_EN to detect an
// unconditional self-jump and park in HALT instead of looping.
// Ports:
//   clk, res_n            : clock, asynchronous active-low reset
//   run                   : 1 = execute, 0 = stop at instruction boundary
//   imem_req/imem_ack     : fetch handshake, instr valid with ack
//   instr                 : fetched instruction
//   zr, ng                : ALU flags, sampled in DECODE
//   a_reg, pc             : jump target and current counter value
//   pc_res/pc_load/pc_inc : counter controls (mutually exclusive)
//   pc_target             : counter load data
//   exec_en               : commit strobe, one cycle per instruction
//   busy, fault, halted   : status
module pc_sequencer
    import hack_cpu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] instr,
    input  logic             zr,
    input  logic             ng,
    input  logic [WIDTH-1:0] a_reg,
    input  logic [WIDTH-1:0] pc,
    output logic             pc_res,
    output logic             pc_load,
    output logic             pc_inc,
    output logic [WIDTH-1:0] pc_target,
    output logic             exec_en,
    output logic             busy,
    output logic             fault,
    output logic             halted
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   ir_q, ir_d;
    logic               take_q, take_d;
    logic               take_w;

    jump_cond u_jump_cond (
        .is_c_i (ir_q[INSTR_TYPE_BIT]),
        .jump_i (ir_q[2:0]),
        .zr_i   (zr),
        .ng_i   (ng),
        .take_o (take_w)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ir_q    <= '0;
            take_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            take_q  <= take_d;
        end
    end

    // Next-state logic. The timeout counter is cleared in every state but
    // FETCH, so it always starts at zero on FETCH entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ir_d    = ir_q;
        take_d  = take_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                // Flags are only valid for this instruction in DECODE.
                take_d  = take_w;
                state_d = ST_EXEC;
`ifdef PC_SEQ_HALT_DETECT_EN
                if (ir_q[INSTR_TYPE_BIT] && (ir_q[2:0] == JMP_ALWAYS) && (a_reg == pc))
                    state_d = ST_HALT;
`endif
            end
            ST_EXEC: begin
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
`ifdef PC_SEQ_HALT_DETECT_EN
            ST_HALT: begin
                if (!run) state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from registered state and take.
    always_comb begin
        pc_res    = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_target = '0;
        imem_req  = 1'b0;
        exec_en   = 1'b0;
        busy      = (state_q != ST_IDLE);
        fault     = (state_q == ST_FAULT);
        halted    = 1'b0;
        case (state_q)
            ST_IDLE:  pc_res = 1'b1;
            ST_FETCH: imem_req = 1'b1;
            ST_EXEC: begin
                exec_en   = 1'b1;
                pc_load   = take_q;
                pc_inc    = ~take_q;
                pc_target = a_reg;
            end
`ifdef PC_SEQ_HALT_DETECT_EN
            ST_HALT:  halted = 1'b1;
`endif
            default: ;
        endcase
    end

    // Only the type and jump fields of ir drive control decisions.
    logic unused_ir;
    assign unused_ir = ^ir_q[WIDTH-2:3];
`ifndef PC_SEQ_HALT_DETECT_EN
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        res_n, run, imem_req, imem_ack;
    logic [15:0] instr, a_reg, pc, pc_target;
    logic        zr, ng, pc_res, pc_load, pc_inc, exec_en, busy, fault, halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(16), .TIMEOUT(15)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .run       (run),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .instr     (instr),
        .zr        (zr),
        .ng        (ng),
        .a_reg     (a_reg),
        .pc        (pc),
        .pc_res    (pc_res),
        .pc_load   (pc_load),
        .pc_inc    (pc_inc),
        .pc_target (pc_target),
        .exec_en   (exec_en),
        .busy      (busy),
        .fault     (fault),
        .halted    (halted)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: ALU result class 0 = positive, 1 = zero, 2 = negative.
    // A C-instruction jumps when the jump field selects that class.
    function automatic bit ref_jump(input logic [15:0] ins, input int cls);
        if (ins[15] == 1'b0) return 1'b0;
        case (cls)
            0:       return ins[0];
            1:       return ins[1];
            default: return ins[2];
        endcase
    endfunction

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge
    // after DECODE.
    task automatic fetch_decode(input logic [15:0] ins, input int waits, input int cls,
                                input logic [15:0] tgt, input logic [15:0] pcv);
        for (int w = 0; w < waits; w++) begin
            check_val("fetch_wait_req", imem_req, 1);
            check_val("fetch_wait_exec", exec_en, 0);
            imem_ack = 1'b0;
            zr = 1'($urandom);
            ng = 1'($urandom);
            @(negedge clk);
        end
        check_val("fetch_req", imem_req, 1);
        check_val("fetch_pc_res", pc_res, 0);
        imem_ack = 1'b1;
        instr    = ins;
        @(negedge clk);
        check_val("decode_req", imem_req, 0);
        check_val("decode_exec", exec_en, 0);
        check_val("decode_busy", busy, 1);
        imem_ack = 1'($urandom);
        instr    = 16'($urandom);
        zr       = (cls == 1);
        ng       = (cls == 2);
        a_reg    = tgt;
        pc       = pcv;
        @(negedge clk);
    endtask

    // At the EXEC negedge; leaves the DUT in FETCH at the following negedge.
    task automatic exec_check(input logic [15:0] ins, input int cls,
                              input logic [15:0] tgt, input bit run_after);
        bit exp_take;
        exp_take = ref_jump(ins, cls);
        check_val("exec_en", exec_en, 1);
        check_val("exec_load", pc_load, exp_take);
        check_val("exec_inc", pc_inc, !exp_take);
        check_val("exec_target", pc_target, tgt);
        check_val("exec_req", imem_req, 0);
        check_val("exec_res", pc_res, 0);
        imem_ack = 1'b0;
        zr  = 1'($urandom);
        ng  = 1'($urandom);
        run = run_after;
        @(negedge clk);
        if (run_after) begin
            check_val("next_fetch_req", imem_req, 1);
            check_val("next_exec_low", exec_en, 0);
        end else begin
            check_val("stop_idle_res", pc_res, 1);
            check_val("stop_idle_busy", busy, 0);
            run = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic reset_dut();
        res_n    = 1'b0;
        run      = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
    endtask

    initial begin
        int n;
        int cls;
        logic [15:0] ins, tgt;
        res_n = 1'b0; run = 1'b0; imem_ack = 1'b0; instr = '0;
        zr = 1'b0; ng = 1'b0; a_reg = 16'h1111; pc = '0;
        #1;
        check_val("rst_pc_res", pc_res, 1);
        check_val("rst_req", imem_req, 0);
        check_val("rst_load", pc_load, 0);
        check_val("rst_inc", pc_inc, 0);
        check_val("rst_exec", exec_en, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_fault", fault, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_target", pc_target, 0);
        @(negedge clk);
        res_n = 1'b1;

        // Asynchronous reset while fetching
        run = 1'b1;
        @(negedge clk);
        check_val("t1_fetch_req", imem_req, 1);
        #2 res_n = 1'b0;
        #1;
        check_val("t1_req", imem_req, 0);
        check_val("t1_pc_res", pc_res, 1);
        check_val("t1_busy", busy, 0);
        check_val("t1_fault", fault, 0);
        @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        check_val("t1_fetch_again", imem_req, 1);

        // A-instruction with two wait cycles, stop afterwards
        fetch_decode(16'h0005, 2, 0, 16'h1234, 16'h0000);
        exec_check(16'h0005, 0, 16'h1234, 1'b0);

        // JEQ taken / not taken
        fetch_decode(16'hE302, 0, 1, 16'h0040, 16'h0003);
        exec_check(16'hE302, 1, 16'h0040, 1'b1);
        fetch_decode(16'hE302, 1, 0, 16'h0040, 16'h0003);
        exec_check(16'hE302, 0, 16'h0040, 1'b1);

        // JMP with any flags, JGT on negative
        cls = $urandom_range(0, 2);
        fetch_decode(16'hE307, 0, cls, 16'h0100, 16'h0007);
        exec_check(16'hE307, cls, 16'h0100, 1'b1);
        fetch_decode(16'hE301, 0, 2, 16'h0100, 16'h0007);
        exec_check(16'hE301, 2, 16'h0100, 1'b1);

        // Random instruction stream
        for (int i = 0; i < 40; i++) begin
            ins = 16'($urandom);
            tgt = 16'($urandom);
            cls = $urandom_range(0, 2);
            fetch_decode(ins, $urandom_range(0, 4), cls, tgt, ~tgt);
            exec_check(ins, cls, tgt, ($urandom_range(0, 2) != 0));
        end

        // Unconditional self-jump
`ifdef PC_SEQ_HALT_DETECT_EN
        fetch_decode(16'hEA87, 0, 1, 16'h0010, 16'h0010);
        check_val("t6_halted", halted, 1);
        check_val("t6_req", imem_req, 0);
        check_val("t6_exec", exec_en, 0);
        check_val("t6_load", pc_load, 0);
        imem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("t6_hold_halted", halted, 1);
            check_val("t6_hold_req", imem_req, 0);
        end
        imem_ack = 1'b0;
        run = 1'b0;
        @(negedge clk);
        check_val("t6_exit_halted", halted, 0);
        check_val("t6_exit_res", pc_res, 1);
        run = 1'b1;
        @(negedge clk);
`else
        repeat (3) begin
            cls = $urandom_range(0, 2);
            fetch_decode(16'hEA87, 0, cls, 16'h0010, 16'h0010);
            check_val("t6_halted", halted, 0);
            exec_check(16'hEA87, cls, 16'h0010, 1'b1);
        end
`endif

        // Fetch timeout
        reset_dut();
        run = 1'b1;
        @(negedge clk);
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check_val("t5_fetch_cycles", n, 15);
        check_val("t5_fault", fault, 1);
        check_val("t5_req", imem_req, 0);
        imem_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_val("t5_hold_fault", fault, 1);
            check_val("t5_hold_exec", exec_en, 0);
            check_val("t5_hold_req", imem_req, 0);
            check_val("t5_hold_ctl", {pc_res, pc_load, pc_inc}, 0);
        end
        #2 res_n = 1'b0;
        #1;
        check_val("t5_rst_fault", fault, 0);
        check_val("t5_rst_pc_res", pc_res, 1);
        @(negedge clk);
        res_n = 1'b1;
        imem_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
